// File: rtl/dr_pkg.sv
// dr_pkg: shared types, limits and the permutation function for the dr_stream
// reorder buffer. The optional second bank is enabled by defining DR_PINGPONG_EN.
package dr_pkg;

  localparam int DR_LOG2_DEPTH_MIN = 1;
  localparam int DR_LOG2_DEPTH_MAX = 8;

  typedef enum logic [1:0] {
    DR_IDENT    = 2'b00,
    DR_REV      = 2'b01,
    DR_BITREV   = 2'b10,
    DR_PAIRSWAP = 2'b11
  } dr_mode_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } dr_rd_state_e;

  // Maps read index r to the bank address for the given mode; only the low
  // log2_depth bits of r are meaningful and the result is confined to them.
  function automatic logic [DR_LOG2_DEPTH_MAX-1:0] dr_perm(
    input dr_mode_e                       mode,
    input logic [DR_LOG2_DEPTH_MAX-1:0]   r,
    input int                             log2_depth
  );
    logic [DR_LOG2_DEPTH_MAX-1:0] ones;
    logic [DR_LOG2_DEPTH_MAX-1:0] mask;
    logic [DR_LOG2_DEPTH_MAX-1:0] rev;
    logic [DR_LOG2_DEPTH_MAX-1:0] res;
    ones = '1;
    mask = ones >> (DR_LOG2_DEPTH_MAX - log2_depth);
    // Reverse all bits, then shift down so only the low log2_depth bits are reversed.
    for (int i = 0; i < DR_LOG2_DEPTH_MAX; i++) rev[i] = r[DR_LOG2_DEPTH_MAX-1-i];
    case (mode)
      DR_IDENT:    res = r;
      DR_REV:      res = mask - r;
      DR_BITREV:   res = rev >> (DR_LOG2_DEPTH_MAX - log2_depth);
      DR_PAIRSWAP: res = r ^ {{(DR_LOG2_DEPTH_MAX-1){1'b0}}, 1'b1};
      default:     res = r;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/dr_bank.sv
// dr_bank: one frame of storage, DEPTH x WIDTH registers with a single write
// port and a combinational read port. Contents are data only and are not reset.
module dr_bank #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: unchanged except the addressed word on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dr_stream.sv
// dr_stream: streaming frame reorder buffer. Frames of 2**LOG2_DEPTH words are
// written in arrival order and replayed in the permutation chosen by the mode
// sampled on each frame's first word. Defining DR_PINGPONG_EN adds a second
// bank so one frame fills while the previous one drains; without it a single
// bank alternates between filling and draining.
module dr_stream
  import dr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             frame_last
);

  localparam int AW = LOG2_DEPTH;
  localparam logic [AW-1:0] IDX_LAST = '1;

  if (LOG2_DEPTH < DR_LOG2_DEPTH_MIN || LOG2_DEPTH > DR_LOG2_DEPTH_MAX) begin : g_bad_depth
    $error("dr_stream: LOG2_DEPTH out of range");
  end

  logic         wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]   full_q, full_d;
  dr_mode_e     mode_q [2];
  dr_mode_e     mode_d [2];
  dr_rd_state_e rd_state_q, rd_state_d;
  logic         rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;

  logic          wr_beat, rd_beat, wr_last, rd_last;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] bank0_rdata;

  // All outputs come straight from registered state.
  assign in_ready   = !full_q[wr_bank_q];
  assign out_valid  = (rd_state_q == RD_DRAIN);
  assign frame_last = out_valid && (rd_idx_q == IDX_LAST);
  assign rd_addr    = AW'(dr_perm(mode_q[rd_bank_q], DR_LOG2_DEPTH_MAX'(rd_idx_q), LOG2_DEPTH));
  assign a          = out_valid ? rd_data : '0;

  dr_bank #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_bank0 (
    .clk   (clk),
    .we    (wr_beat && !wr_bank_q),
    .waddr (wr_idx_q),
    .wdata (d),
    .raddr (rd_addr),
    .rdata (bank0_rdata)
  );

`ifdef DR_PINGPONG_EN
  logic [WIDTH-1:0] bank1_rdata;

  dr_bank #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_bank1 (
    .clk   (clk),
    .we    (wr_beat && wr_bank_q),
    .waddr (wr_idx_q),
    .wdata (d),
    .raddr (rd_addr),
    .rdata (bank1_rdata)
  );

  assign rd_data = rd_bank_q ? bank1_rdata : bank0_rdata;
`else
  assign rd_data = bank0_rdata;
`endif

  // Write fill, full flags, mode capture and read-side drain/handover decisions.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    full_d     = full_q;
    mode_d     = mode_q;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;

    wr_beat = in_valid && in_ready;
    rd_beat = out_valid && out_ready;
    wr_last = wr_beat && (wr_idx_q == IDX_LAST);
    rd_last = rd_beat && (rd_idx_q == IDX_LAST);

    if (wr_beat) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + 1'b1;
      if (wr_idx_q == '0) mode_d[wr_bank_q] = dr_mode_e'(mode);
    end

    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
`ifdef DR_PINGPONG_EN
      wr_bank_d = ~wr_bank_q;
`else
      wr_bank_d = 1'b0;
`endif
    end

    // The read bank is always full and the write bank never is, so these never collide.
    if (rd_last) full_d[rd_bank_q] = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (wr_last) begin
          rd_state_d = RD_DRAIN;
          rd_bank_d  = wr_bank_q;
          rd_idx_d   = '0;
        end
      end
      RD_DRAIN: begin
        if (rd_last) begin
          rd_idx_d = '0;
          // A frame waiting in the other bank (or completing on this edge) starts at once.
          if (full_d[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else if (rd_beat) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Control state register; clear discards every frame and any drain in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      mode_q     <= '{default: DR_IDENT};
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      mode_q     <= mode_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_dr_stream.sv
// tb_dr_stream: directed bench for dr_stream with a frame-level reference model.
module tb_dr_stream;

  localparam int D  = 4;
  localparam int L2 = 2;
`ifdef DR_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, in_valid, in_ready, out_valid, out_ready, frame_last;
  logic [7:0] d, a;
  logic [1:0] mode;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, frame_last8;
  logic [7:0] d8, a8;
  logic [1:0] mode8;

  dr_stream #(.WIDTH(8), .LOG2_DEPTH(2)) u_dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .d(d), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .frame_last(frame_last)
  );

  dr_stream #(.WIDTH(8), .LOG2_DEPTH(3)) u_dut8 (
    .clk(clk), .clear(clear), .in_valid(in_valid8), .in_ready(in_ready8), .d(d8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .a(a8), .frame_last(frame_last8)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state: words still to come out, frame being written, log of beats.
  exp_t       exp_q[$];
  logic [7:0] part[$];
  logic [1:0] part_mode;
  logic [7:0] log_q[$];
  int         log_cyc[$];
  int         cyc = 0;
  int         frame_done_cyc = 0;
  logic       chk_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_a = '0;
  int         low_cnt = 0;

  function automatic int perm(input logic [1:0] m, input int r);
    int v;
    v = 0;
    case (m)
      2'd0: v = r;
      2'd1: v = D - 1 - r;
      2'd2: for (int b = 0; b < L2; b++) if ((r >> b) & 1) v = v | (1 << (L2 - 1 - b));
      default: v = r ^ 1;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of the DUT against the model, then model update with this cycle's beats.
  always @(negedge clk) begin
    if (chk_en) begin
      int   held;
      exp_t e;
      held = (exp_q.size() + D - 1) / D;
      check("in_ready", in_ready, held < NBANK);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        check("a", a, exp_q[0].data);
        check("frame_last", frame_last, exp_q[0].last);
      end else if (!out_valid) begin
        check("a_idle", a, 0);
        check("frame_last_idle", frame_last, 0);
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", a, prev_a);
      end
      prev_stall = out_valid && !out_ready && !clear;
      prev_a = a;
      if (clear) begin
        exp_q.delete();
        part.delete();
      end else begin
        if (out_valid && out_ready) begin
          log_q.push_back(a);
          log_cyc.push_back(cyc);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          if (part.size() == 0) part_mode = mode;
          part.push_back(d);
          if (part.size() == D) begin
            for (int r = 0; r < D; r++) begin
              e.data = part[perm(part_mode, r)];
              e.last = (r == D - 1);
              exp_q.push_back(e);
            end
            part.delete();
            frame_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    d = w;
    mode = m;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      low_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && part.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      if (!in_ready) low_cnt++;
      @(posedge clk); #1;
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic expect_seq(input string name, input int base, input logic [7:0] e [12], input int n);
    check({name, "_count"}, log_q.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < log_q.size()) check(name, log_q[base + i], e[i]);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_a"}, a, 0);
    check({name, "_frame_last"}, frame_last, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [7:0] got [8];
    logic       gl [8];
    logic [7:0] exp8 [8];

    clear = 1'b1; in_valid = 1'b0; d = '0; mode = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; d8 = '0; mode8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    chk_en = 1'b1;
    check_reset_outputs("reset");

    // Reverse mode; later mode changes inside the frame must be ignored.
    base = log_q.size();
    send(8'd1, 2'b01); send(8'd2, 2'b11); send(8'd5, 2'b00); send(8'd6, 2'b10);
    wait_drain();
    expect_seq("s1_rev", base, '{6, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0}, 4);
    if (log_cyc.size() > base) check("s1_latency", log_cyc[base], frame_done_cyc - 3 + 1 + 3);

    // Two frames back to back, pair-swap then identity.
    base = log_q.size();
    low_cnt = 0;
    send(8'd8, 2'b11); send(8'd10, 2'b11); send(8'd12, 2'b11); send(8'd13, 2'b11);
    send(8'd12, 2'b00); send(8'd4, 2'b00); send(8'd3, 2'b00); send(8'd2, 2'b00);
    wait_drain();
    expect_seq("s3_stream", base, '{10, 8, 13, 12, 12, 4, 3, 2, 0, 0, 0, 0}, 8);
`ifdef DR_PINGPONG_EN
    check("s3_in_ready_low", low_cnt, 0);
    if (log_cyc.size() >= base + 8)
      for (int i = 1; i < 8; i++) check("s3_no_bubble", log_cyc[base + i] - log_cyc[base + i - 1], 1);
`else
    check("s6_in_ready_low", low_cnt, 2 * D);
`endif

    // Back-pressure with out_ready pattern 1,0,0,1 across three frames.
    base = log_q.size();
    low_cnt = 0;
    fork
      begin
        send(8'd3, 2'b00); send(8'd1, 2'b00); send(8'd4, 2'b00); send(8'd1, 2'b00);
        send(8'd5, 2'b01); send(8'd9, 2'b01); send(8'd2, 2'b01); send(8'd6, 2'b01);
        send(8'd5, 2'b10); send(8'd3, 2'b10); send(8'd5, 2'b10); send(8'd8, 2'b10);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    expect_seq("s4_backpressure", base, '{3, 1, 4, 1, 6, 2, 9, 5, 5, 5, 3, 8}, 12);
    check("s4_in_ready_stalled", low_cnt > 0, 1);

    // Clear after a partial frame, with a write beat in the same cycle.
    send(8'd11, 2'b00); send(8'd22, 2'b00);
    in_valid = 1'b1; d = 8'd33; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check_reset_outputs("clear_partial");

    // Clear in the middle of a drain: no further output from that frame.
    base = log_q.size();
    send(8'd7, 2'b01); send(8'd8, 2'b01); send(8'd9, 2'b01); send(8'd10, 2'b01);
    for (int k = 0; k < 50; k++) begin
      if (log_q.size() > base) break;
      @(posedge clk); #1;
    end
    n = log_q.size();
    check("s5_first_word", n - base, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_reset_outputs("clear_drain");
    repeat (6) @(posedge clk);
    #1;
    check("s5_no_more_output", log_q.size(), n);

    base = log_q.size();
    send(8'd1, 2'b00); send(8'd0, 2'b00); send(8'd6, 2'b00); send(8'd9, 2'b00);
    wait_drain();
    expect_seq("s5_after_clear", base, '{1, 0, 6, 9, 0, 0, 0, 0, 0, 0, 0, 0}, 4);

    // Eight-word frame in bit-reverse mode on the LOG2_DEPTH=3 instance.
    exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'b1;
      d8 = 8'(i);
      mode8 = 2'b10;
      for (int k = 0; k < 50; k++) begin
        if (in_ready8) break;
        @(posedge clk); #1;
      end
      check("s2_in_ready", in_ready8, 1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      if (out_valid8) begin
        got[n] = a8;
        gl[n] = frame_last8;
        n++;
      end else begin
        check("s2_a_idle", a8, 0);
      end
      @(posedge clk); #1;
    end
    check("s2_count", n, 8);
    for (int i = 0; i < n; i++) begin
      check("s2_bitrev", got[i], exp8[i]);
      check("s2_frame_last", gl[i], i == 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dr_stream.md
# dr_stream

Parametrised streaming data-reordering buffer, successor to the 4-entry `dr` reorder block. Accepts frames of `2**LOG2_DEPTH` words on a valid/ready input stream and replays each frame in a permuted order selected per frame by `mode`. Storage is ping-pong so one frame can be written while the previous one drains. Sits between the sample front-end and the transform datapath.

## Interface
- `WIDTH`, 8: data word width in bits.
- `LOG2_DEPTH`, 2: log2 of frame length; `DEPTH = 2**LOG2_DEPTH`; legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input word present.
- `in_ready` out 1: buffer can accept a word this cycle.
- `d` in WIDTH: input word.
- `mode` in 2: permutation, sampled on the first beat of each frame.
- `out_valid` out 1: output word present.
- `out_ready` in 1: downstream accepts the word this cycle.
- `a` out WIDTH: output word.
- `frame_last` out 1: high with the last output word of a frame.

## Operation
- Write beat: `in_valid && in_ready`. Read beat: `out_valid && out_ready`.
- Writes fill the write bank at addresses 0..DEPTH-1 in arrival order. `mode` is captured into that bank's mode register on write index 0. Changes to `mode` mid-frame are ignored.
- Read index r runs 0..DEPTH-1. Output `a = bank[perm(mode_bank, r)]`.
- Permutation by mode:
  - 00: identity, r.
  - 01: reverse, DEPTH-1-r.
  - 10: bit-reverse of the LOG2_DEPTH-bit r.
  - 11: pair-swap, r^1.
- Each bank has a full flag. Write side states: FILL (bank not full). Read side states: IDLE and DRAIN.
- Handover:
  - When the write bank becomes full and the read side is IDLE (or finishes its last read beat on the same edge), the read side takes that bank and enters DRAIN with r=0.
  - On the same edge the write pointer flips to the other bank.
  - If the other bank is still draining, `in_ready` is 0 until that drain ends.
- The last read beat (r=DEPTH-1) returns the read side to IDLE, or hands over directly if a full bank is waiting.
- `out_valid` and `a` hold stable while `out_ready`=0.
- `a` is 0 whenever `out_valid`=0.
- `frame_last` = `out_valid && r==DEPTH-1`.
- `clear` discards all partial and full frames. Any drain in progress is aborted with no further output.
- Outputs after reset: `in_ready`=1, `out_valid`=0, `a`=0, `frame_last`=0, both banks empty, r=0.

## Timing
- Latency: the first output word is valid in the cycle after the edge that accepted the frame's last input word.
- With `out_ready` held at 1 and `in_valid` held at 1, throughput is 1 word/cycle in and out with no bubbles at frame boundaries.
- `in_ready`, `out_valid`, `a` and `frame_last` depend only on registered state. There is no combinational path from `in_valid`, `out_ready` or `d` to any output.
- Simultaneous write of the last word and read of the last word hands both banks over on the same edge.
- `clear` takes priority over any beat in the same cycle. The next cycle shows the reset values.

## Configuration
- `DR_PINGPONG_EN` defined: two banks, behaviour as above.
- `DR_PINGPONG_EN` undefined: one bank only.
  - `in_ready` falls on the edge that accepts word DEPTH-1.
  - `in_ready` rises on the edge of the last read beat.
  - Sustained throughput is DEPTH words per 2·DEPTH cycles.
  - Latency and permutations are unchanged.

## Structure
- Package `dr_pkg` holds:
  - the mode typedef `dr_mode_e` (DR_IDENT, DR_REV, DR_BITREV, DR_PAIRSWAP);
  - the function `dr_perm(mode, r, log2_depth)`;
  - the constants for the LOG2_DEPTH limits.
- Sub-module `dr_bank`: DEPTH×WIDTH register array with write port and combinational read port. Instantiated once or twice under `DR_PINGPONG_EN`.
- Top level holds the write/read FSMs, the full flags and the mode registers.

## Test plan
1. WIDTH=8, LOG2_DEPTH=2, mode=01, inputs 1,2,5,6, `out_ready`=1 -> outputs 6,5,2,1. `frame_last` high on the 1. First output valid 1 cycle after the 6 is accepted.
2. LOG2_DEPTH=3, mode=10, inputs 0..7 -> outputs 0,4,2,6,1,5,3,7.
3. mode=11, inputs 8,10,12,13 then mode=00, inputs 12,4,3,2 back-to-back -> outputs 10,8,13,12,12,4,3,2 with no idle cycle; `in_ready` stays 1 (ping-pong).
4. Back-pressure: `out_ready` toggled 1,0,0,1,… -> `a` holds while stalled. With both banks full, `in_ready`=0 until the drain ends. No word lost or duplicated.
5. `clear` pulsed after 2 of 4 inputs and again mid-drain -> reset outputs the next cycle. The following frame 1,0,6,9 with mode=00 emerges intact as 1,0,6,9.
6. Build without `DR_PINGPONG_EN`, frames streamed continuously -> `in_ready` low for exactly DEPTH cycles per frame with `out_ready`=1. Output sequence identical to scenario 3.
